// File: rtl/key_sequencer_if.sv
// Valid/ready byte channels between keyboard, key_sequencer and the usb_uart uart_in pipe.
// master: the sequencer's view; slave: the surrounding keyboard/uart side.
interface key_sequencer_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

   modport slave (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

// File: rtl/key_sequencer.sv
// Expands keyboard special codes into VT52 ESC sequences; plain ASCII passes through unchanged.
// Optional macro KEY_SEQUENCER_CRLF_EN: a CR byte is expanded into CR followed by LF.
module key_sequencer #(
   parameter logic [7:0] ESC_CHAR = 8'h1B,
   parameter logic [7:0] KEY_BASE = 8'h80
) (
   input  logic            clk,
   input  logic            reset,
   key_sequencer_if.master bus,
   output logic            busy
);

   typedef enum logic {IDLE, SEQ} state_t;

   state_t     state_q, state_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] pend_q, pend_d;

   logic       accept;
   logic       drain;
   logic [7:0] idx;
   logic       special;
   logic       known;

   // Up/Down/Right/Left map to 'A'..'D', PF1..PF4 map to 'P'..'S'.
   function automatic logic [7:0] final_char(input logic [2:0] k);
      case (k)
         3'd0:    final_char = 8'h41;
         3'd1:    final_char = 8'h42;
         3'd2:    final_char = 8'h43;
         3'd3:    final_char = 8'h44;
         3'd4:    final_char = 8'h50;
         3'd5:    final_char = 8'h51;
         3'd6:    final_char = 8'h52;
         default: final_char = 8'h53;
      endcase
   endfunction

   assign bus.in_ready  = reset && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign busy          = (state_q == SEQ);

   assign accept  = bus.in_valid && bus.in_ready;
   assign drain   = out_valid_q && bus.out_ready;
   assign idx     = bus.in_data - KEY_BASE;
   assign special = (bus.in_data >= KEY_BASE);
   assign known   = (idx < 8'd8);

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      pend_d      = pend_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!special) begin
`ifdef KEY_SEQUENCER_CRLF_EN
                  if (bus.in_data == 8'h0D) begin
                     out_data_d  = 8'h0D;
                     out_valid_d = 1'b1;
                     pend_d      = 8'h0A;
                     state_d     = SEQ;
                  end else begin
                     out_data_d  = bus.in_data;
                     out_valid_d = 1'b1;
                  end
`else
                  out_data_d  = bus.in_data;
                  out_valid_d = 1'b1;
`endif
               end else if (known) begin
                  out_data_d  = ESC_CHAR;
                  out_valid_d = 1'b1;
                  pend_d      = final_char(idx[2:0]);
                  state_d     = SEQ;
               end else if (drain) begin
                  // Unknown special code: swallowed, only retire the byte just drained.
                  out_valid_d = 1'b0;
               end
            end else if (drain) begin
               out_valid_d = 1'b0;
            end
         end
         SEQ: begin
            if (bus.out_ready) begin
               out_data_d  = pend_q;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         pend_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         pend_q      <= pend_d;
      end
   end

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer: reset, pass-through, escape expansion, drops, CR handling, mid-sequence reset.
module tb_key_sequencer;
   logic clk;
   logic reset;
   logic busy;
   int   total;
   int   passed;
   int   failed;

   key_sequencer_if bus ();

   key_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic b);
      chk({tag, "_valid"}, {7'd0, bus.out_valid}, {7'd0, v});
      if (v) chk({tag, "_data"}, bus.out_data, d);
      chk({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
   endtask

   task automatic chk_rdy(input string tag, input logic r);
      #1;
      chk(tag, {7'd0, bus.in_ready}, {7'd0, r});
   endtask

   initial begin
      total  = 0;
      passed = 0;
      failed = 0;
      reset  = 1'b0;
      bus.in_data   = 8'h61;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;

      // Reset held two cycles with input offered.
      step();
      step();
      chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd0);
      chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("rst_out_data", bus.out_data, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      step();
      chk_rdy("rel_in_ready", 1'b1);
      chk_out("rel", 1'b0, 8'h00, 1'b0);

      // Back-to-back plain bytes.
      bus.in_data  = 8'h61;
      bus.in_valid = 1'b1;
      chk_rdy("p61_rdy", 1'b1);
      step();
      chk_out("p61", 1'b1, 8'h61, 1'b0);
      bus.in_data = 8'h62;
      chk_rdy("p62_rdy", 1'b1);
      step();
      chk_out("p62", 1'b1, 8'h62, 1'b0);
      bus.in_valid = 1'b0;
      step();
      chk_out("p_idle", 1'b0, 8'h00, 1'b0);

      // Up arrow with a stalled consumer.
      bus.in_data   = 8'h80;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      chk_rdy("up_rdy", 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk_out("up_esc", 1'b1, 8'h1B, 1'b1);
      chk_rdy("up_esc_rdy", 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("up_stall", 1'b1, 8'h1B, 1'b1);
         chk_rdy("up_stall_rdy", 1'b0);
      end
      bus.out_ready = 1'b1;
      chk_rdy("up_seq_rdy", 1'b0);
      step();
      chk_out("up_fin", 1'b1, 8'h41, 1'b0);
      chk_rdy("up_fin_rdy", 1'b1);
      step();
      chk_out("up_done", 1'b0, 8'h00, 1'b0);

      // PF4 then an unknown special code.
      bus.in_data  = 8'h87;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk_out("pf4_esc", 1'b1, 8'h1B, 1'b1);
      step();
      chk_out("pf4_fin", 1'b1, 8'h53, 1'b0);
      step();
      chk_out("pf4_done", 1'b0, 8'h00, 1'b0);
      bus.in_data  = 8'h90;
      bus.in_valid = 1'b1;
      chk_rdy("unk_rdy", 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk_out("unk", 1'b0, 8'h00, 1'b0);
      chk_rdy("unk_rdy_after", 1'b1);

      // Carriage return.
      bus.in_data  = 8'h0D;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
`ifdef KEY_SEQUENCER_CRLF_EN
      chk_out("cr", 1'b1, 8'h0D, 1'b1);
      step();
      chk_out("lf", 1'b1, 8'h0A, 1'b0);
`else
      chk_out("cr", 1'b1, 8'h0D, 1'b0);
      step();
      chk_out("no_lf", 1'b0, 8'h00, 1'b0);
`endif
      step();
      chk_out("cr_done", 1'b0, 8'h00, 1'b0);

      // Left arrow interrupted by reset while ESC is presented.
      bus.in_data   = 8'h83;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      chk_out("left_esc", 1'b1, 8'h1B, 1'b1);
      reset = 1'b0;
      chk_rdy("left_rst_rdy", 1'b0);
      step();
      chk_out("left_rst", 1'b0, 8'h00, 1'b0);
      chk("left_rst_data", bus.out_data, 8'h00);
      reset = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("left_after", 1'b0, 8'h00, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
